fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 3PA pipeline, directly upstream of the IF/ID `pipereg`. It owns the program counter and issues one-outstanding instruction-memory requests. It presents `{pc, instruction}` plus a flush strobe to the IF/ID register. It holds a fetched instruction while the hazard unit stalls, and discards in-flight responses after a branch/jump redirect.

## Interface
- `WIDTH`, 32: address and instruction width.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `PC_STEP`, 4: PC increment per instruction.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit holding IF/ID; same signal drives that `pipereg`'s `stall`.
- `redirect`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  WIDTH  target address, valid with `redirect`.
- `imem_req`  out  1  memory request; held high until `imem_ack`.
- `imem_addr`  out  WIDTH  request address; stable while `imem_req`=1.
- `imem_ack`  in  1  response valid this cycle; may coincide with the first cycle of `imem_req`.
- `imem_rdata`  in  WIDTH  instruction, valid with `imem_ack`.
- `if_pc`  out  WIDTH  address of the presented instruction (to IF/ID `in`).
- `if_instr`  out  WIDTH  presented instruction (to IF/ID `in`).
- `if_valid`  out  1  `if_pc`/`if_instr` meaningful this cycle.
- `if_flush`  out  1  to IF/ID `flush`: `redirect | ~if_valid`.

## Operation
- State registers: `state`, `pc` (next address to fetch), `drain_addr`, and `hold_pc`/`hold_instr`.
- FSM states: IDLE, REQ, HOLD, DRAIN.
- Priority each cycle: `rst` > `redirect` > `stall` > normal.
- **IDLE** (entered on reset):
  - `imem_req`=0, `if_valid`=0.
  - Next cycle goes to REQ.
  - A stray `imem_ack` is ignored.
- **REQ**:
  - `imem_req`=1, `imem_addr`=`pc`.
  - No ack: `if_valid`=0; stay.
  - Ack: `if_valid`=1, `if_instr`=`imem_rdata`, `if_pc`=`pc`.
    - `stall`=0: `pc`<=`pc`+`PC_STEP`; stay in REQ.
    - `stall`=1: capture into hold regs; go HOLD.
- **HOLD**:
  - `imem_req`=0, `if_valid`=1, outputs come from the hold regs.
  - `stall`=0: `pc`<=`pc`+`PC_STEP`; go REQ.
- **DRAIN**:
  - `imem_req`=1, `imem_addr`=`drain_addr`, `if_valid`=0.
  - On ack: discard data; go REQ (`pc` already holds the target).
- **Redirect** (any non-IDLE state): `pc`<=`redirect_pc`, `if_flush`=1.
  - REQ without ack same cycle: `drain_addr`<=`pc`; go DRAIN.
  - REQ with ack, HOLD, or DRAIN with ack: go REQ.
  - DRAIN without ack: stay DRAIN; `drain_addr` is unchanged.
  - A redirect in IDLE is ignored.
- **Arithmetic**: `pc`+`PC_STEP` is modulo 2^WIDTH; wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- When `if_valid`=0 the values of `if_pc`/`if_instr` are don't-care; the bench checks only `if_flush`.

## Timing
- **Reset values**: state IDLE, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_flush`=1, hold regs and `drain_addr` = 0.
- `imem_*`, `if_*` are combinational from state, hold regs and same-cycle `imem_ack`/`imem_rdata`/`redirect`; there are no registered outputs.
- **Fetch latency**: the first `imem_req` comes 1 cycle after `rst` deasserts. With a zero-wait memory, sustained throughput is 1 instruction/cycle.
- **Redirect latency**: the target address appears on `imem_addr` in the cycle after `redirect`, or one cycle after the draining ack.
- **Reset mid-operation**: takes effect at the next edge in every state. The memory shares `rst` and drops outstanding requests.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE, REQ, HOLD, DRAIN).
  - Default `PC_STEP`.
- Single module with no sub-module. The hold buffer is inline conditional-load registers, not a `pipereg` instance, because its load enable is not a stall/flush pair.

## Test plan
- **Reset then zero-wait memory** (ack with every req, `stall`=0) -> `imem_addr` 0, 4, 8, 12 on consecutive cycles; `if_valid`=1 from the first REQ cycle; `if_flush`=0.
- **2-wait-state memory**: ack 2 cycles after req -> `imem_addr` held at 0x4 for 3 cycles; `if_valid`=1 and `if_flush`=0 only in the ack cycle.
- **Stall**: `stall`=1 for 3 cycles during an ack at pc 0x10 -> HOLD; `if_instr`/`if_pc`=0x10 stable; `imem_req`=0. After release, the next `imem_addr` is 0x14.
- **Redirect with request outstanding**: redirect to 0x200 while REQ at 0x8 is unacked -> DRAIN keeps `imem_addr`=0x8. The ack's data never appears with `if_valid`=1. The next request is 0x200.
- **Redirect and stall together** in HOLD -> redirect wins; `if_flush`=1; the next `imem_addr` is `redirect_pc`.
- **Wrap and reset**: `RESET_PC`=32'hFFFF_FFFC -> the second fetch address is 0. Asserting `rst` during DRAIN -> IDLE next cycle with `pc`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int FETCH_PC_STEP = 4;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding imem requests,
// buffers a fetched instruction across stalls and drains stale responses after redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               PC_STEP  = FETCH_PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             if_valid,
    output logic             if_flush
);

    fetch_state_t     state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] drain_addr_reg, drain_addr_next;
    logic [WIDTH-1:0] hold_pc_reg, hold_instr_reg;
    logic             hold_load;
    logic [WIDTH-1:0] pc_inc;

    // Wraps modulo 2^WIDTH by construction.
    assign pc_inc = pc_reg + WIDTH'(PC_STEP);

    assign imem_req  = (state_reg == REQ) || (state_reg == DRAIN);
    assign imem_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    assign if_valid  = ((state_reg == REQ) && imem_ack) || (state_reg == HOLD);
    assign if_pc     = (state_reg == HOLD) ? hold_pc_reg    : pc_reg;
    assign if_instr  = (state_reg == HOLD) ? hold_instr_reg : imem_rdata;
    assign if_flush  = redirect | ~if_valid;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        hold_load       = 1'b0;
        unique case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                    if (!imem_ack) begin
                        // The unacked request must still complete before the target is fetched.
                        drain_addr_next = pc_reg;
                        state_next      = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_load  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (!stall) begin
                    pc_next    = pc_inc;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_next = redirect_pc;
                end
                if (imem_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
            hold_pc_reg    <= '0;
            hold_instr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            if (hold_load) begin
                hold_pc_reg    <= pc_reg;
                hold_instr_reg <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table on a RESET_PC=0 instance
// plus a short PC-wrap sequence on a second instance.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, if_valid, if_flush;
    logic [31:0] imem_addr, if_pc, if_instr;

    logic        w_rst = 1'b1, w_ack = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_req, w_valid, w_flush;
    logic [31:0] w_addr, w_pc, w_instr;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_flush(if_flush)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .rst(w_rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .if_pc(w_pc), .if_instr(w_instr), .if_valid(w_valid), .if_flush(w_flush)
    );

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk_addr, e_valid;
        logic [31:0] e_pc;
        logic        e_flush;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic a, input logic [31:0] d, input logic eq, input logic [31:0] ea,
                       input logic ca, input logic ev, input logic [31:0] ep, input logic ef);
        vecs.push_back('{r, s, rd, rpc, a, d, eq, ea, ca, ev, ep, ef});
    endtask

    initial begin
        //   rst stl rd  rpc         ack rdata          req addr        chk val pc          flush
        add(1, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   1); // reset state
        add(0, 0, 0, 32'h0,   1, 32'h55,        0, 32'h0,   1, 0, 32'h0,   1); // stray ack in IDLE
        add(0, 0, 0, 32'h0,   1, 32'hA000_0000, 1, 32'h0,   1, 1, 32'h0,   0); // zero-wait run
        add(0, 0, 0, 32'h0,   1, 32'hA000_0004, 1, 32'h4,   1, 1, 32'h4,   0);
        add(0, 0, 0, 32'h0,   1, 32'hA000_0008, 1, 32'h8,   1, 1, 32'h8,   0);
        add(0, 0, 0, 32'h0,   1, 32'hA000_000C, 1, 32'hC,   1, 1, 32'hC,   0);
        add(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h10,  1, 0, 32'h0,   1); // 2 wait states
        add(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h10,  1, 0, 32'h0,   1);
        add(0, 0, 0, 32'h0,   1, 32'hA000_0010, 1, 32'h10,  1, 1, 32'h10,  0);
        add(0, 1, 0, 32'h0,   1, 32'hA000_0014, 1, 32'h14,  1, 1, 32'h14,  0); // stall on ack
        add(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0, 1, 32'h14,  0);
        add(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0, 1, 32'h14,  0);
        add(0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   0, 1, 32'h14,  0); // release
        add(0, 0, 0, 32'h0,   1, 32'hA000_0018, 1, 32'h18,  1, 1, 32'h18,  0);
        add(0, 0, 1, 32'h200, 0, 32'h0,         1, 32'h1C,  1, 0, 32'h0,   1); // redirect, unacked
        add(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h1C,  1, 0, 32'h0,   1);
        add(0, 0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h1C,  1, 0, 32'h0,   1); // drained ack
        add(0, 0, 0, 32'h0,   1, 32'hA000_0200, 1, 32'h200, 1, 1, 32'h200, 0);
        add(0, 0, 1, 32'h300, 0, 32'h0,         1, 32'h204, 1, 0, 32'h0,   1);
        add(0, 0, 1, 32'h400, 0, 32'h0,         1, 32'h204, 1, 0, 32'h0,   1); // redirect in DRAIN
        add(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h204, 1, 0, 32'h0,   1);
        add(0, 0, 1, 32'h500, 1, 32'hDEAD_BEEF, 1, 32'h204, 1, 0, 32'h0,   1);
        add(0, 0, 0, 32'h0,   1, 32'hA000_0500, 1, 32'h500, 1, 1, 32'h500, 0);
        add(0, 1, 0, 32'h0,   1, 32'hA000_0504, 1, 32'h504, 1, 1, 32'h504, 0);
        add(0, 1, 1, 32'h600, 0, 32'h0,         0, 32'h0,   0, 1, 32'h504, 1); // redirect beats stall
        add(0, 0, 0, 32'h0,   1, 32'hA000_0600, 1, 32'h600, 1, 1, 32'h600, 0);
        add(0, 0, 1, 32'h700, 1, 32'hA000_0604, 1, 32'h604, 1, 1, 32'h604, 1); // redirect with ack
        add(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h700, 1, 0, 32'h0,   1);
        add(0, 0, 1, 32'h800, 0, 32'h0,         1, 32'h700, 1, 0, 32'h0,   1);
        add(1, 0, 0, 32'h0,   0, 32'h0,         1, 32'h700, 1, 0, 32'h0,   1); // reset in DRAIN
        add(0, 0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   1, 0, 32'h0,   1);
        add(0, 0, 0, 32'h0,   1, 32'hA000_0000, 1, 32'h0,   1, 1, 32'h0,   0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
            #1;
            check("imem_req", i, 32'(imem_req), 32'(vecs[i].e_req));
            check("if_valid", i, 32'(if_valid), 32'(vecs[i].e_valid));
            check("if_flush", i, 32'(if_flush), 32'(vecs[i].e_flush));
            if (vecs[i].chk_addr) check("imem_addr", i, imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) begin
                check("if_pc", i, if_pc, vecs[i].e_pc);
                check("if_instr", i, if_instr, 32'hA000_0000 | vecs[i].e_pc);
            end
            $display("row %0d: req=%0b addr=%h valid=%0b pc=%h instr=%h flush=%0b",
                     i, imem_req, imem_addr, if_valid, if_pc, if_instr, if_flush);
        end

        // Wrap sequence: RESET_PC = FFFF_FFFC, zero-wait memory.
        @(negedge clk); w_rst = 1'b0; #1;
        check("wrap idle req", 100, 32'(w_req), 32'h0);
        check("wrap idle addr", 100, w_addr, 32'hFFFF_FFFC);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_a;
            exp_a = 32'hFFFF_FFFC + 32'(4 * k);
            @(negedge clk); w_ack = 1'b1; w_rdata = 32'hB000_0000 | exp_a; #1;
            check("wrap addr", 101 + k, w_addr, exp_a);
            check("wrap valid", 101 + k, 32'(w_valid), 32'h1);
            check("wrap if_pc", 101 + k, w_pc, exp_a);
            $display("wrap %0d: req=%0b addr=%h valid=%0b pc=%h", k, w_req, w_addr, w_valid, w_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
